selector_arbiter: RTL and testbench

//   Shares one unique_selector instance between N_REQ requesters.
//   - Arbitration: round-robin.
//   - Per draw: issues a single-cycle draw request, waits for done,

---
 rtl/selector_arbiter_if.sv | 27 ++
 rtl/selector_arbiter.sv | 118 +++++++++++
 tb/tb_selector_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/selector_arbiter_if.sv
// Client and selector-side signals of selector_arbiter; master is the arbiter side,
// slave is the side that owns the client requests and the unique_selector.
interface selector_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] cli_req;
  logic [N_REQ-1:0] cli_ack;
  logic [2:0]       cli_num;
  logic [N_REQ-1:0] cli_grant;
  logic             exhausted;
  logic             timeout_err;
  logic             busy;
  logic             sel_req;
  logic             sel_done;
  logic [2:0]       sel_number;
  logic             sel_all;

  modport master (
    input  cli_req, sel_done, sel_number, sel_all,
    output cli_ack, cli_num, cli_grant, exhausted, timeout_err, busy, sel_req
  );

  modport slave (
    output cli_req, sel_done, sel_number, sel_all,
    input  cli_ack, cli_num, cli_grant, exhausted, timeout_err, busy, sel_req
  );
endinterface

// File: rtl/selector_arbiter.sv
// Round-robin share of one unique_selector among N_REQ clients; with zero gap and a
// 1-cycle selector, cli_req at t gives sel_req at t+1 and cli_ack at t+3.
module selector_arbiter #(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic               clk,
  input  logic               rst,
  selector_arbiter_if.master bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_WAIT_DONE = 3'd2;
  localparam logic [2:0] S_GAP       = 3'd3;
  localparam logic [2:0] S_EXHAUSTED = 3'd4;

  logic [2:0]       state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    grant_id;
  logic [PW-1:0]    winner;
  logic [PW-1:0]    scan_idx;
  logic [PW-1:0]    next_ptr;
  logic [31:0]      timer;
  logic [31:0]      gap_cnt;
  logic [N_REQ-1:0] ack_q;
  logic [2:0]       num_q;
  logic             terr_q;
  logic [N_REQ-1:0] grant_oh;

  function automatic int wrap_idx(input int v);
    return (v >= N_REQ) ? v - N_REQ : v;
  endfunction

  // Scan from the highest offset down so the lowest offset from rr_ptr wins last.
  always_comb begin
    winner   = rr_ptr;
    scan_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      scan_idx = PW'(wrap_idx(int'(rr_ptr) + i));
      if (bus.cli_req[scan_idx]) begin
        winner = scan_idx;
      end
    end
  end

  assign next_ptr = (grant_id == PW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign grant_oh = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id;

  // timer holds the number of cycles elapsed since the ISSUE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      timer    <= '0;
      gap_cnt  <= '0;
      ack_q    <= '0;
      num_q    <= '0;
      terr_q   <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state)
        S_IDLE: begin
          if (bus.sel_all) begin
            state <= S_EXHAUSTED;
          end else if (|bus.cli_req) begin
            grant_id <= winner;
            timer    <= '0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= timer + 32'd1;
          state <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (bus.sel_done) begin
            num_q   <= bus.sel_number;
            ack_q   <= grant_oh;
            rr_ptr  <= next_ptr;
            gap_cnt <= '0;
            state   <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          end else if (timer == 32'(TIMEOUT - 1)) begin
            terr_q <= 1'b1;
            rr_ptr <= next_ptr;
            state  <= S_IDLE;
          end else begin
            timer <= timer + 32'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt == 32'(GAP_CYCLES - 1)) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        S_EXHAUSTED: begin
          state <= S_EXHAUSTED;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.sel_req     = (state == S_ISSUE);
  assign bus.busy        = (state == S_ISSUE) || (state == S_WAIT_DONE) || (state == S_GAP);
  assign bus.exhausted   = (state == S_EXHAUSTED);
  assign bus.cli_grant   = ((state == S_ISSUE) || (state == S_WAIT_DONE)) ? grant_oh : '0;
  assign bus.cli_ack     = ack_q;
  assign bus.cli_num     = num_q;
  assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_selector_arbiter.sv
// Directed bench for selector_arbiter: two instances (4 clients/no gap, 3 clients/16-cycle gap)
// each driven by a small unique_selector model; expected acks are queued and popped on each ack.
module tb_selector_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic sel_dead;
  int   cnt_a, cnt_b;
  int   pass_cnt = 0;
  int   total    = 0;
  int   exp_qa[$];
  int   exp_qb[$];
  int   idx_a, idx_b;
  logic [7:0] seen_a;

  always #5 clk = ~clk;

  selector_arbiter_if #(.N_REQ(4)) if_a ();
  selector_arbiter_if #(.N_REQ(3)) if_b ();

  selector_arbiter #(.N_REQ(4), .GAP_CYCLES(0), .TIMEOUT(64)) u_dut (
    .clk(clk), .rst(rst), .bus(if_a)
  );
  selector_arbiter #(.N_REQ(3), .GAP_CYCLES(16), .TIMEOUT(64)) u_gap (
    .clk(clk), .rst(rst), .bus(if_b)
  );

  function automatic logic [2:0] perm(input int i);
    case (i & 7)
      0: return 3'd5;
      1: return 3'd2;
      2: return 3'd7;
      3: return 3'd0;
      4: return 3'd3;
      5: return 3'd6;
      6: return 3'd1;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] oh(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return one << i;
  endfunction

  // Selector models: done one cycle after req, numbers from a fixed permutation.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      if_a.sel_done <= 1'b0; if_a.sel_number <= 3'd0; if_a.sel_all <= 1'b0; cnt_a <= 0;
    end else begin
      if_a.sel_done <= 1'b0;
      if (if_a.sel_req && !sel_dead && cnt_a < 8) begin
        if_a.sel_done   <= 1'b1;
        if_a.sel_number <= perm(cnt_a);
        cnt_a           <= cnt_a + 1;
        if (cnt_a == 7) if_a.sel_all <= 1'b1;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      if_b.sel_done <= 1'b0; if_b.sel_number <= 3'd0; if_b.sel_all <= 1'b0; cnt_b <= 0;
    end else begin
      if_b.sel_done <= 1'b0;
      if (if_b.sel_req && cnt_b < 8) begin
        if_b.sel_done   <= 1'b1;
        if_b.sel_number <= perm(cnt_b);
        cnt_b           <= cnt_b + 1;
        if (cnt_b == 7) if_b.sel_all <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    chk("leftover_exp_a", exp_qa.size(), 0);
    chk("leftover_exp_b", exp_qb.size(), 0);
    exp_qa.delete();
    exp_qb.delete();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst    = 1'b0;
    idx_a  = 0;
    idx_b  = 0;
    seen_a = 8'h00;
    @(negedge clk);
  endtask

  task automatic wait_grant_a(input int budget);
    int c = 0;
    while (if_a.cli_grant == 4'b0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("grant_seen", {31'b0, if_a.cli_grant != 4'b0}, 1);
  endtask

  task automatic run_acks(input int inst, input int n, input int budget);
    int got = 0;
    int cyc = 0;
    int last_ack = -1;
    int e;
    logic [3:0] ack, grant;
    logic [2:0] num;
    logic sreq;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (inst == 0) begin
        ack = if_a.cli_ack; grant = if_a.cli_grant; num = if_a.cli_num; sreq = if_a.sel_req;
      end else begin
        ack = {1'b0, if_b.cli_ack}; grant = {1'b0, if_b.cli_grant};
        num = if_b.cli_num; sreq = if_b.sel_req;
      end
      if (sreq) begin
        if (inst == 0 && exp_qa.size() > 0) chk("grant", grant, oh(exp_qa[0]));
        else if (inst == 1 && exp_qb.size() > 0) chk("grant", grant, oh(exp_qb[0]));
        else chk("unexpected_grant", grant, 0);
        if (inst == 1 && last_ack >= 0) chk("gap_spacing_ge17", {31'b0, (cyc - last_ack) >= 17}, 1);
      end
      if (ack != 4'b0) begin
        got++;
        last_ack = cyc;
        if (inst == 0 && exp_qa.size() > 0) begin
          e = exp_qa.pop_front();
          chk("ack_client", ack, oh(e));
        end else if (inst == 1 && exp_qb.size() > 0) begin
          e = exp_qb.pop_front();
          chk("ack_client", ack, oh(e));
        end else begin
          chk("unexpected_ack", ack, 0);
        end
        if (inst == 0) begin
          chk("ack_num", num, perm(idx_a));
          idx_a++;
          seen_a = seen_a | (8'b1 << num);
        end else begin
          chk("ack_num", num, perm(idx_b));
          idx_b++;
        end
      end
    end
    chk("ack_count", got, n);
  endtask

  initial begin
    int n, pulses, acks, c;
    logic any_grant, any_ack;
    rst = 1'b1;
    sel_dead = 1'b0;
    if_a.cli_req = 4'b0;
    if_b.cli_req = 3'b0;
    idx_a = 0; idx_b = 0; seen_a = 8'h00;

    // Reset values
    @(negedge clk);
    chk("rst_ack", if_a.cli_ack, 0);
    chk("rst_num", if_a.cli_num, 0);
    chk("rst_grant", if_a.cli_grant, 0);
    chk("rst_exhausted", if_a.exhausted, 0);
    chk("rst_timeout_err", if_a.timeout_err, 0);
    chk("rst_busy", if_a.busy, 0);
    chk("rst_sel_req", if_a.sel_req, 0);
    do_reset();

    // Single client drains all 8 numbers
    if_a.cli_req = 4'b0001;
    repeat (8) exp_qa.push_back(0);
    run_acks(0, 8, 200);
    chk("perm_all_numbers", seen_a, 8'hFF);
    any_grant = 1'b0; any_ack = 1'b0;
    repeat (20) begin
      @(negedge clk);
      any_grant |= (if_a.cli_grant != 4'b0);
      any_ack   |= (if_a.cli_ack != 4'b0);
    end
    chk("exhausted", if_a.exhausted, 1);
    chk("exh_no_grant", any_grant, 0);
    chk("exh_no_ack", any_ack, 0);
    chk("exh_busy", if_a.busy, 0);
    chk("cli_num_held", if_a.cli_num, perm(7));
    if_a.cli_req = 4'b0;
    do_reset();

    // All clients: strict round robin
    if_a.cli_req = 4'b1111;
    for (int i = 0; i < 8; i++) exp_qa.push_back(i % 4);
    run_acks(0, 8, 200);
    @(negedge clk);
    chk("rr_exhausted", if_a.exhausted, 1);
    if_a.cli_req = 4'b0;
    do_reset();

    // rr_ptr=1 after client 0 draws: 0101 gives 2 then 0
    if_a.cli_req = 4'b0001;
    exp_qa.push_back(0); exp_qa.push_back(2); exp_qa.push_back(0);
    wait_grant_a(20);
    if_a.cli_req = 4'b0101;
    run_acks(0, 3, 100);
    if_a.cli_req = 4'b0;
    do_reset();

    // Dead selector: watchdog
    sel_dead = 1'b1;
    if_a.cli_req = 4'b0010;
    c = 0;
    while (!if_a.sel_req && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("to_issue_seen", if_a.sel_req, 1);
    n = 0; pulses = 0; acks = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (if_a.sel_req) pulses++;
      if (if_a.cli_ack != 4'b0) acks++;
      if (!if_a.busy) break;
    end
    if_a.cli_req = 4'b0;
    chk("to_idle_after", n, 64);
    chk("to_extra_sel_req", pulses, 0);
    chk("to_no_ack", acks, 0);
    chk("to_err", if_a.timeout_err, 1);
    repeat (10) @(negedge clk);
    chk("to_err_sticky", if_a.timeout_err, 1);
    chk("to_busy_idle", if_a.busy, 0);
    sel_dead = 1'b0;
    do_reset();

    // Reset mid-draw, then first grant back at client 0
    if_a.cli_req = 4'b0010;
    exp_qa.push_back(1);
    wait_grant_a(20);
    if_a.cli_req = 4'b0;
    run_acks(0, 1, 50);
    sel_dead = 1'b1;
    if_a.cli_req = 4'b1000;
    c = 0;
    while (!if_a.sel_req && c < 20) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    chk("mid_grant", if_a.cli_grant, 4'b1000);
    chk("mid_busy", if_a.busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_grant", if_a.cli_grant, 0);
    chk("arst_busy", if_a.busy, 0);
    chk("arst_sel_req", if_a.sel_req, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idx_a = 0; seen_a = 8'h00;
    sel_dead = 1'b0;
    if_a.cli_req = 4'b1111;
    exp_qa.push_back(0);
    wait_grant_a(20);
    chk("post_rst_grant", if_a.cli_grant, 4'b0001);
    if_a.cli_req = 4'b0;
    run_acks(0, 1, 50);
    do_reset();

    // Gap spacing and non-power-of-2 wrap
    if_b.cli_req = 3'b111;
    exp_qb.push_back(0); exp_qb.push_back(1); exp_qb.push_back(2); exp_qb.push_back(0);
    run_acks(1, 4, 400);
    if_b.cli_req = 3'b0;
    do_reset();

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
